ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter N_CH, default 2, number of requester channels (1..8); channel 0 is the instruction fetch and channel 1 is the data port.
REQ-002 Parameter ADDR_W, default 32, width of the address bus.
REQ-003 Parameter DATA_BYTES, default 4, maximum transfer size in bytes (power of two, 1..8).
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_in  input  1  reset; one clock, asynchronous, active-low.
REQ-006 rdy_in  input  1  global pause; low freezes all state.
REQ-007 req_valid  input  N_CH  per-channel request; held stable until that channel's resp_done.
REQ-008 req_rw  input  N_CH  1 = write, 0 = read.
REQ-009 req_size  input  N_CH*3  log2 of the byte count; values above log2(DATA_BYTES) are clamped.
REQ-010 req_signed  input  N_CH  1 = sign-extend a narrow read.
REQ-011 req_addr  input  N_CH*ADDR_W  start byte address.
REQ-012 req_wdata  input  N_CH*8*DATA_BYTES  write data, little-endian.
REQ-013 abort  input  N_CH  cancels an in-flight read (see Configuration).
REQ-014 resp_done  output  N_CH  one-cycle completion pulse.
REQ-015 resp_data  output  8*DATA_BYTES  read result shared by all channels; valid only in the resp_done cycle.
REQ-016 busy  output  1  high when the FSM is not IDLE.
REQ-017 ram_din  input  8  RAM read byte.
REQ-018 ram_dout  output  8  RAM write byte.
REQ-019 ram_a  output  ADDR_W  RAM byte address.
REQ-020 ram_wr  output  1  1 = write strobe.

Function
REQ-021 The FSM SHALL have the states IDLE, XFER and DONE.
REQ-022 In IDLE with any req_valid high, the arbiter SHALL grant the first requesting channel at or after rr_ptr (wrapping) and enter XFER on the next edge.
REQ-023 rr_ptr SHALL advance to grant+1 (mod N_CH) on entry to DONE.
REQ-024 In XFER cycle k (k = 0..n-1, n = 2^size), ram_a SHALL equal addr+k, wrapping mod 2^ADDR_W.
REQ-025 For a write, ram_wr SHALL be 1 and ram_dout SHALL equal wdata byte k during each XFER cycle k.
REQ-026 For a read, ram_wr SHALL be 0, and the byte on ram_din in cycle k+1 SHALL be captured into result byte k.
REQ-027 A read SHALL occupy n+1 XFER cycles and a write n XFER cycles; DONE follows immediately.
REQ-028 In DONE, resp_done[grant] SHALL be 1 for exactly one cycle; resp_data SHALL be zero-extended, or sign-extended when req_signed is 1, from n bytes.
REQ-029 DONE SHALL always return to IDLE, and req_valid SHALL be ignored during DONE, so back-to-back grants are separated by one idle cycle.
REQ-030 Outside XFER, ram_wr SHALL be 0 and ram_a SHALL hold its last value.
REQ-031 Request inputs SHALL be sampled once at grant; later changes have no effect until DONE.
REQ-032 With rdy_in low, all state SHALL freeze, ram_wr SHALL be forced to 0, and resp_done SHALL be 0; the operation resumes at the same k when rdy_in returns high.
REQ-033 Simultaneous requests SHALL be resolved strictly by rr_ptr; no channel waits more than N_CH-1 grants.

Reset
REQ-034 When rst_in is low, the block SHALL asynchronously set: state = IDLE, rr_ptr = 0, resp_done = 0, resp_data = 0, ram_wr = 0, ram_a = 0, ram_dout = 0, busy = 0.
REQ-035 A reset mid-transfer SHALL drop the transfer with no resp_done; the requester reissues it.

Configuration
REQ-036 The macro RAM_ARB_ABORT_EN SHALL control the abort feature.
REQ-037 When RAM_ARB_ABORT_EN is defined, abort[grant] high during an XFER read SHALL return the FSM to IDLE on the next edge with no resp_done, and rr_ptr SHALL advance.
REQ-038 When RAM_ARB_ABORT_EN is defined, abort SHALL be ignored during writes and on non-granted channels.
REQ-039 When RAM_ARB_ABORT_EN is undefined, the abort port SHALL exist but be ignored.

Structure
REQ-040 A shared package ram_arb_pkg SHALL hold the state encoding (IDLE/XFER/DONE) and the size-code constants SZ_B = 0, SZ_H = 1, SZ_W = 2.
REQ-041 One sub-module, rr_arbiter, SHALL implement the combinational round-robin pick (inputs: req vector and rr_ptr; outputs: grant index and a valid flag).

Verification
REQ-042 Scenario: ch1 read, size 2, addr 0x100, RAM bytes 11 22 33 84, signed -> ram_a 0x100..0x103 in XFER cycles 0..3; resp_done[1] in DONE with resp_data 0x84332211.
REQ-043 Scenario: ch1 read, size 0, addr 0x7, byte 0x80, signed then unsigned -> resp_data 0xFFFFFF80 then 0x00000080.
REQ-044 Scenario: ch0 and ch1 request in the same cycle with rr_ptr = 0, then both repeat -> grant order ch0, ch1, ch0, ch1.
REQ-045 Scenario: ch1 write, size 1, addr 0xFFFFFFFF, wdata 0xBEEF -> ram_wr = 1 on ram_a 0xFFFFFFFF (ram_dout 0xEF) then on ram_a 0x0 (ram_dout 0xBE); resp_done after 2 XFER cycles.
REQ-046 Scenario: rdy_in low for 3 cycles during read byte 2 -> ram_a frozen, no resp_done during the pause, final resp_data unchanged vs. the unpaused run.
REQ-047 Scenario (RAM_ARB_ABORT_EN defined): abort[0] during XFER cycle 1 of a ch0 read -> IDLE next edge, resp_done stays 0, next grant goes to ch1 if it is pending.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter: FSM encoding, transfer size codes
// and the helper that turns a requested size code into the index of the last byte.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    // Oversized requests are clamped to the widest transfer the bus supports.
    function automatic logic [3:0] last_index(input logic [2:0] size, input int log2_max);
        logic [2:0] clamped;
        clamped = (int'(size) > log2_max) ? 3'(log2_max) : size;
        return 4'((1 << clamped) - 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response and byte-wide RAM signals of the arbiter, grouped into one bundle.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface ram_arbiter_if #(
    parameter int N_CH       = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4
);

    logic [N_CH-1:0]              req_valid;
    logic [N_CH-1:0]              req_rw;
    logic [N_CH*3-1:0]            req_size;
    logic [N_CH-1:0]              req_signed;
    logic [N_CH*ADDR_W-1:0]       req_addr;
    logic [N_CH*8*DATA_BYTES-1:0] req_wdata;
    logic [N_CH-1:0]              abort;
    logic [N_CH-1:0]              resp_done;
    logic [8*DATA_BYTES-1:0]      resp_data;
    logic                         busy;
    logic [7:0]                   ram_din;
    logic [7:0]                   ram_dout;
    logic [ADDR_W-1:0]            ram_a;
    logic                         ram_wr;

    modport slave (
        input  req_valid, req_rw, req_size, req_signed, req_addr, req_wdata, abort, ram_din,
        output resp_done, resp_data, busy, ram_dout, ram_a, ram_wr
    );

    modport master (
        output req_valid, req_rw, req_size, req_signed, req_addr, req_wdata, abort, ram_din,
        input  resp_done, resp_data, busy, ram_dout, ram_a, ram_wr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_CH = 2,
    parameter int PW   = 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [PW-1:0]   grant,
    output logic            valid
);

    int idx;

    // Scan from the farthest candidate back to rr_ptr so the closest requester wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_CH;
            if (req[idx]) begin
                grant = PW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving N_CH requesters byte-serial access to a single-port RAM.
// Optional feature: define RAM_ARB_ABORT_EN to let the granted channel cancel a read.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    ram_arbiter_if.slave  bus
);

    localparam int PW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int LOG2_DB = $clog2(DATA_BYTES);
    localparam int DW      = 8 * DATA_BYTES;

    state_t            state, state_nx;
    logic [PW-1:0]     rr_ptr, grant, pick, ptr_next;
    logic              pick_valid, rw_q, signed_q, abort_hit, xfer_last, sign_bit;
    logic [3:0]        k_q, last_k;
    logic [DW-1:0]     wdata_q, result_q, cap_next, ext_data, resp_data_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_dout_q, dout_next;

    rr_arbiter #(.N_CH(N_CH), .PW(PW)) u_rr (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick),
        .valid  (pick_valid)
    );

`ifdef RAM_ARB_ABORT_EN
    assign abort_hit = (state == XFER) && !rw_q && bus.abort[grant];
`else
    logic unused_abort;
    assign unused_abort = ^bus.abort;
    assign abort_hit    = 1'b0;
`endif

    // A read needs one extra cycle because RAM data lags its address by a cycle.
    assign xfer_last = rw_q ? (k_q == last_k) : (k_q == last_k + 4'd1);
    assign ptr_next  = (grant == PW'(N_CH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        cap_next  = result_q;
        dout_next = ram_dout_q;
        sign_bit  = 1'b0;
        ext_data  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (k_q == 4'(i + 1)) cap_next[8*i +: 8] = bus.ram_din;
            if (k_q + 4'd1 == 4'(i)) dout_next = wdata_q[8*i +: 8];
        end
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (last_k == 4'(i)) sign_bit = signed_q & cap_next[8*i + 7];
        end
        for (int i = 0; i < DATA_BYTES; i++) begin
            ext_data[8*i +: 8] = (4'(i) <= last_k) ? cap_next[8*i +: 8] : {8{sign_bit}};
        end
    end

    always_comb begin
        state_nx = state;
        if (rdy_in) begin
            case (state)
                IDLE:    if (pick_valid) state_nx = XFER;
                XFER:    if (abort_hit) state_nx = IDLE;
                         else if (xfer_last) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    // Request fields are latched once at grant; the requester may change them afterwards.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr      <= '0;
            grant       <= '0;
            rw_q        <= 1'b0;
            signed_q    <= 1'b0;
            k_q         <= '0;
            last_k      <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            resp_data_q <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: if (pick_valid) begin
                    grant      <= pick;
                    rw_q       <= bus.req_rw[pick];
                    signed_q   <= bus.req_signed[pick];
                    last_k     <= last_index(bus.req_size[int'(pick)*3 +: 3], LOG2_DB);
                    wdata_q    <= bus.req_wdata[int'(pick)*DW +: DW];
                    ram_a_q    <= bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
                    ram_dout_q <= bus.req_wdata[int'(pick)*DW +: 8];
                    k_q        <= '0;
                    result_q   <= '0;
                end
                XFER: begin
                    if (abort_hit) begin
                        rr_ptr <= ptr_next;
                    end else begin
                        if (!rw_q) result_q <= cap_next;
                        if (xfer_last) begin
                            rr_ptr <= ptr_next;
                            if (!rw_q) resp_data_q <= ext_data;
                        end else begin
                            k_q <= k_q + 4'd1;
                            if (k_q < last_k) begin
                                ram_a_q    <= ram_a_q + 1'b1;
                                ram_dout_q <= dout_next;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_done = (state == DONE && rdy_in) ? (N_CH'(1) << grant) : '0;
    assign bus.resp_data = resp_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = (state == XFER) && rw_q && rdy_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// compared against a byte-array memory model and a round-robin grant model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int N_CH       = 2;
    localparam int ADDR_W     = 32;
    localparam int DATA_BYTES = 4;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    ram_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES)) bus ();

    ram_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          m_ptr;
    bit          pend    [N_CH];
    logic        p_rw    [N_CH];
    logic [2:0]  p_size  [N_CH];
    logic        p_sgn   [N_CH];
    logic [31:0] p_addr  [N_CH];
    logic [31:0] p_wdata [N_CH];

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return def_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return def_byte(a);
    endfunction

    function automatic int n_bytes(input logic [2:0] size);
        return 1 << ((int'(size) > 2) ? 2 : int'(size));
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] size, input logic sgn);
        int          n;
        logic [31:0] v;
        n = n_bytes(size);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
        if (sgn && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < N_CH; i++) if (pend[(m_ptr + i) % N_CH]) return (m_ptr + i) % N_CH;
        return -1;
    endfunction

    // Synchronous RAM: data appears one cycle after its address; the pause freezes it too.
    always @(posedge clk_in) begin
        logic [7:0] rd;
        if (rdy_in) begin
            rd = ram_rd(bus.ram_a);
            bus.ram_din <= rd;
            if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
        end
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic applyStimulus(input int ch, input logic rw, input logic [2:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd);
        p_rw[ch] = rw; p_size[ch] = sz; p_sgn[ch] = sg; p_addr[ch] = a; p_wdata[ch] = wd;
        pend[ch] = 1'b1;
        bus.req_rw[ch]            = rw;
        bus.req_size[ch*3 +: 3]   = sz;
        bus.req_signed[ch]        = sg;
        bus.req_addr[ch*32 +: 32] = a;
        bus.req_wdata[ch*32 +: 32] = wd;
        bus.req_valid[ch]         = 1'b1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        bus.req_valid = '0;
        bus.abort = '0;
        for (int c = 0; c < N_CH; c++) pend[c] = 1'b0;
        #1;
        n_checks += 6;
        if (bus.busy !== 1'b0)      begin n_errors++; $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); end
        if (bus.resp_done !== '0)   begin n_errors++; $display("[TB] FAIL reset resp_done: got %b expected 00", bus.resp_done); end
        if (bus.ram_wr !== 1'b0)    begin n_errors++; $display("[TB] FAIL reset ram_wr: got %b expected 0", bus.ram_wr); end
        if (bus.ram_a !== '0)       begin n_errors++; $display("[TB] FAIL reset ram_a: got %h expected 0", bus.ram_a); end
        if (bus.ram_dout !== '0)    begin n_errors++; $display("[TB] FAIL reset ram_dout: got %h expected 0", bus.ram_dout); end
        if (bus.resp_data !== '0)   begin n_errors++; $display("[TB] FAIL reset resp_data: got %h expected 0", bus.resp_data); end
        repeat (2) begin
            @(negedge clk_in);
            n_checks++;
            if (bus.resp_done !== '0) begin n_errors++; $display("[TB] FAIL reset held resp_done: got %b expected 00", bus.resp_done); end
        end
        rst_in = 1'b1;
        m_ptr = 0;
    endtask

    // Called at a negedge with the DUT idle and channel g the one the model expects to win.
    task automatic run_xfer(input int g);
        int          n, cycles;
        logic [31:0] exp_a, exp_d;
        n      = n_bytes(p_size[g]);
        cycles = p_rw[g] ? n : n + 1;
        exp_d  = p_rw[g] ? 32'h0 : ref_read(p_addr[g], p_size[g], p_sgn[g]);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_in);
            exp_a = p_addr[g] + 32'(k);
            n_checks += 2;
            if (bus.ram_wr !== (p_rw[g] && k < n)) begin n_errors++; $display("[TB] FAIL xfer ram_wr ch%0d k=%0d: got %b expected %b", g, k, bus.ram_wr, p_rw[g]); end
            if (bus.resp_done !== '0) begin n_errors++; $display("[TB] FAIL xfer early resp_done ch%0d k=%0d: got %b expected 00", g, k, bus.resp_done); end
            if (k < n) begin
                n_checks++;
                if (bus.ram_a !== exp_a) begin n_errors++; $display("[TB] FAIL xfer ram_a ch%0d k=%0d: got %h expected %h", g, k, bus.ram_a, exp_a); end
                if (p_rw[g]) begin
                    n_checks++;
                    if (bus.ram_dout !== p_wdata[g][8*k +: 8]) begin n_errors++; $display("[TB] FAIL xfer ram_dout ch%0d k=%0d: got %h expected %h", g, k, bus.ram_dout, p_wdata[g][8*k +: 8]); end
                end
            end
        end
        @(negedge clk_in);
        n_checks++;
        if (bus.resp_done !== N_CH'(1 << g)) begin n_errors++; $display("[TB] FAIL done resp_done ch%0d: got %b expected %b", g, bus.resp_done, N_CH'(1 << g)); end
        if (!p_rw[g]) begin
            n_checks++;
            if (bus.resp_data !== exp_d) begin n_errors++; $display("[TB] FAIL done resp_data ch%0d addr %h: got %h expected %h", g, p_addr[g], bus.resp_data, exp_d); end
        end else begin
            for (int i = 0; i < n; i++) ref_mem[p_addr[g] + 32'(i)] = p_wdata[g][8*i +: 8];
        end
        m_ptr = (g + 1) % N_CH;
        pend[g] = 1'b0;
        bus.req_valid[g] = 1'b0;
        @(negedge clk_in);
        n_checks += 2;
        if (bus.busy !== 1'b0)    begin n_errors++; $display("[TB] FAIL idle busy after ch%0d: got %b expected 0", g, bus.busy); end
        if (bus.resp_done !== '0) begin n_errors++; $display("[TB] FAIL idle resp_done after ch%0d: got %b expected 00", g, bus.resp_done); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_read_signed();
        applyStimulus(1, 1'b0, SZ_W, 1'b1, 32'h100, 32'h0);
        run_xfer(model_pick());
    endtask

    task automatic test_read_byte();
        applyStimulus(1, 1'b0, SZ_B, 1'b1, 32'h7, 32'h0);
        run_xfer(model_pick());
        applyStimulus(1, 1'b0, SZ_B, 1'b0, 32'h7, 32'h0);
        run_xfer(model_pick());
    endtask

    task automatic test_reset_mid();
        applyStimulus(1, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
        repeat (2) @(negedge clk_in);
        do_reset();
        @(negedge clk_in);
        applyStimulus(1, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
        run_xfer(model_pick());
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk_in);
        applyStimulus(0, 1'b0, SZ_B, 1'b0, 32'h200, 32'h0);
        applyStimulus(1, 1'b0, SZ_B, 1'b0, 32'h201, 32'h0);
        for (int i = 0; i < 4; i++) begin
            int g;
            g = model_pick();
            run_xfer(g);
            applyStimulus(g, 1'b0, SZ_B, 1'b0, 32'h200 + 32'(g), 32'h0);
        end
        run_xfer(model_pick());
        run_xfer(model_pick());
    endtask

    task automatic test_write_wrap();
        applyStimulus(1, 1'b1, SZ_H, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF);
        run_xfer(model_pick());
        applyStimulus(1, 1'b0, SZ_H, 1'b0, 32'hFFFF_FFFF, 32'h0);
        run_xfer(model_pick());
    endtask

    task automatic test_pause();
        logic [31:0] exp_d;
        exp_d = ref_read(32'h100, SZ_W, 1'b0);
        applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
        repeat (3) @(negedge clk_in);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            n_checks += 3;
            if (bus.ram_a !== 32'h102) begin n_errors++; $display("[TB] FAIL pause ram_a %0d: got %h expected 00000102", i, bus.ram_a); end
            if (bus.resp_done !== '0) begin n_errors++; $display("[TB] FAIL pause resp_done %0d: got %b expected 00", i, bus.resp_done); end
            if (bus.busy !== 1'b1)    begin n_errors++; $display("[TB] FAIL pause busy %0d: got %b expected 1", i, bus.busy); end
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (bus.ram_a !== 32'h103) begin n_errors++; $display("[TB] FAIL resume ram_a: got %h expected 00000103", bus.ram_a); end
        repeat (2) @(negedge clk_in);
        n_checks += 2;
        if (bus.resp_done !== 2'b01) begin n_errors++; $display("[TB] FAIL pause done resp_done: got %b expected 01", bus.resp_done); end
        if (bus.resp_data !== exp_d) begin n_errors++; $display("[TB] FAIL pause resp_data: got %h expected %h", bus.resp_data, exp_d); end
        pend[0] = 1'b0; bus.req_valid[0] = 1'b0; m_ptr = 1;
        @(negedge clk_in);
        // A paused write must drop its strobe and still land both bytes once resumed.
        applyStimulus(1, 1'b1, SZ_H, 1'b0, 32'h300, 32'h0000_A5C3);
        @(negedge clk_in);
        rdy_in = 1'b0;
        @(negedge clk_in);
        n_checks += 2;
        if (bus.ram_wr !== 1'b0)   begin n_errors++; $display("[TB] FAIL pause write ram_wr: got %b expected 0", bus.ram_wr); end
        if (bus.ram_a !== 32'h300) begin n_errors++; $display("[TB] FAIL pause write ram_a: got %h expected 00000300", bus.ram_a); end
        rdy_in = 1'b1;
        repeat (2) @(negedge clk_in);
        n_checks++;
        if (bus.resp_done !== 2'b10) begin n_errors++; $display("[TB] FAIL pause write resp_done: got %b expected 10", bus.resp_done); end
        ref_mem[32'h300] = 8'hC3; ref_mem[32'h301] = 8'hA5;
        pend[1] = 1'b0; bus.req_valid[1] = 1'b0; m_ptr = 0;
        @(negedge clk_in);
        applyStimulus(0, 1'b0, SZ_H, 1'b0, 32'h300, 32'h0);
        run_xfer(model_pick());
    endtask

    task automatic test_abort();
        do_reset();
        @(negedge clk_in);
        applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
        applyStimulus(1, 1'b0, SZ_B, 1'b0, 32'h7, 32'h0);
`ifdef RAM_ARB_ABORT_EN
        repeat (2) @(negedge clk_in);
        bus.abort[0] = 1'b1;
        @(negedge clk_in);
        n_checks += 2;
        if (bus.busy !== 1'b0)    begin n_errors++; $display("[TB] FAIL abort busy: got %b expected 0", bus.busy); end
        if (bus.resp_done !== '0) begin n_errors++; $display("[TB] FAIL abort resp_done: got %b expected 00", bus.resp_done); end
        bus.abort = '0;
        pend[0] = 1'b0; bus.req_valid[0] = 1'b0; m_ptr = 1;
        run_xfer(model_pick());
`else
        bus.abort[0] = 1'b1;
        run_xfer(model_pick());
        bus.abort = '0;
        run_xfer(model_pick());
`endif
        applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'h400, $urandom);
        bus.abort = '1;
        run_xfer(model_pick());
        applyStimulus(1, 1'b0, SZ_W, 1'b1, 32'h400, 32'h0);
        bus.abort = 2'b01;
        run_xfer(model_pick());
        bus.abort = '0;
    endtask

    task automatic random_req(input int ch);
        logic [31:0] a;
        a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                        : 32'h200 + 32'($urandom_range(0, 15));
        applyStimulus(ch, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            for (int c = 0; c < N_CH; c++) if (!pend[c] && $urandom_range(0, 1) == 1) random_req(c);
            if (model_pick() < 0) random_req($urandom_range(0, N_CH - 1));
            run_xfer(model_pick());
        end
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        bus.req_valid = '0; bus.req_rw = '0; bus.req_size = '0; bus.req_signed = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.abort = '0; bus.ram_din = '0;
        rdy_in = 1'b1;
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h84);
        preload(32'h7, 8'h80);
        test_reset();
        @(negedge clk_in);
        test_read_signed();
        test_read_byte();
        test_reset_mid();
        test_round_robin();
        test_write_wrap();
        test_pause();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
